// File: rtl/token_requester.sv
`default_nettype none
// ============================================================================
// token_requester : job-queue driven req/ack four-phase requester with
//                   timeout abort, protocol checking and grant statistics.
// Revision 1.0
// ============================================================================
module token_requester #(
  parameter int DEPTH   = 4,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     job_valid,
  input  logic [LEN_W-1:0]         job_len,
  output logic                     job_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     req,
  input  logic                     ack,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_err,
  output logic                     proto_err,
  input  logic                     err_clr,
  output logic [CNT_W-1:0]         grant_cnt,
  output logic [CNT_W-1:0]         max_wait
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT);
  localparam int MW = (WW > CNT_W) ? WW : CNT_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  mem_q [DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       count_q, count_d;
  logic [LEN_W-1:0]  hold_q, hold_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic              req_q, req_d;
  logic              done_q, done_d;
  logic              to_q, pe_q;
  logic              to_set, pe_set;
  logic [CNT_W-1:0]  grant_q, grant_d;
  logic [CNT_W-1:0]  maxw_q, maxw_d;
  logic              push, pop;
  logic [LEN_W-1:0]  head_len;
  logic [MW-1:0]     wait_ext, maxw_ext;

  assign job_ready = (count_q != (AW+1)'(DEPTH));
  assign push      = job_valid && job_ready;
  assign head_len  = mem_q[rd_q];
  assign wait_ext  = MW'(wait_q);
  assign maxw_ext  = MW'(maxw_q);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    done_d  = 1'b0;
    hold_d  = hold_q;
    wait_d  = wait_q;
    grant_d = grant_q;
    maxw_d  = maxw_q;
    to_set  = 1'b0;
    pe_set  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          hold_d  = (head_len == '0) ? LEN_W'(1) : head_len;
          wait_d  = '0;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack) begin
          state_d = HOLD;
          if (grant_q != '1) grant_d = grant_q + 1'b1;
          // Wait count may be wider than the stats counter; clamp on record.
          if (wait_ext > maxw_ext)
            maxw_d = (wait_ext > MW'({CNT_W{1'b1}})) ? '1 : CNT_W'(wait_q);
        end else if (wait_q == WW'(TIMEOUT-1)) begin
          req_d   = 1'b0;
          to_set  = 1'b1;
          state_d = RELEASE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      HOLD: begin
        if (!ack) pe_set = 1'b1;
        if (hold_q == LEN_W'(1)) begin
          req_d   = 1'b0;
          done_d  = 1'b1;
          state_d = RELEASE;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      RELEASE: begin
        if (!ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    count_d = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= job_len;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      hold_q  <= '0;
      wait_q  <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      pe_q    <= 1'b0;
      grant_q <= '0;
      maxw_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      hold_q  <= hold_d;
      wait_q  <= wait_d;
      req_q   <= req_d;
      done_q  <= done_d;
      // A new error on the same edge as a clear must survive.
      to_q    <= to_set | (to_q & ~err_clr);
      pe_q    <= pe_set | (pe_q & ~err_clr);
      grant_q <= grant_d;
      maxw_q  <= maxw_d;
    end
  end

  assign fifo_count  = count_q;
  assign req         = req_q;
  assign busy        = (state_q == HOLD);
  assign done        = done_q;
  assign timeout_err = to_q;
  assign proto_err   = pe_q;
  assign grant_cnt   = grant_q;
  assign max_wait    = maxw_q;

endmodule
`default_nettype wire

// File: tb/tb_token_requester.sv
`default_nettype none
// tb_token_requester : directed test-plan scenarios plus randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_token_requester;

  localparam int DEPTH   = 4;
  localparam int LEN_W   = 4;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 8;
  localparam int SAT     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             job_valid = 1'b0;
  logic [LEN_W-1:0] job_len = '0;
  logic             job_ready;
  logic [2:0]       fifo_count;
  logic             req;
  logic             ack = 1'b0;
  logic             busy, done, timeout_err, proto_err;
  logic             err_clr = 1'b0;
  logic [CNT_W-1:0] grant_cnt, max_wait;

  token_requester #(.DEPTH(DEPTH), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .job_valid(job_valid), .job_len(job_len),
    .job_ready(job_ready), .fifo_count(fifo_count), .req(req), .ack(ack),
    .busy(busy), .done(done), .timeout_err(timeout_err), .proto_err(proto_err),
    .err_clr(err_clr), .grant_cnt(grant_cnt), .max_wait(max_wait)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  bit auto_ack = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: job queue plus the phase of the current job.
  localparam int PH_IDLE = 0, PH_WAIT_GRANT = 1, PH_OWN = 2, PH_WAIT_DROP = 3;
  int mq[$];
  int m_phase, m_hold, m_waited, m_grant, m_maxw;
  bit m_req, m_done, m_to, m_pe;

  task automatic model_reset();
    mq.delete();
    m_phase = PH_IDLE; m_hold = 0; m_waited = 0; m_grant = 0; m_maxw = 0;
    m_req = 0; m_done = 0; m_to = 0; m_pe = 0;
  endtask

  task automatic model_step(input bit jv, input int jl, input bit a, input bit clr);
    bit ready, tset, pset, nd;
    ready = (mq.size() < DEPTH);
    tset = 0; pset = 0; nd = 0;
    case (m_phase)
      PH_IDLE: if (mq.size() > 0) begin
        m_hold = mq.pop_front();
        if (m_hold == 0) m_hold = 1;
        m_waited = 0; m_req = 1; m_phase = PH_WAIT_GRANT;
      end
      PH_WAIT_GRANT: begin
        if (a) begin
          m_phase = PH_OWN;
          if (m_grant < SAT) m_grant++;
          if (m_waited > m_maxw) m_maxw = (m_waited > SAT) ? SAT : m_waited;
        end else if (m_waited == TIMEOUT - 1) begin
          m_req = 0; tset = 1; m_phase = PH_WAIT_DROP;
        end else m_waited++;
      end
      PH_OWN: begin
        if (!a) pset = 1;
        if (m_hold == 1) begin m_req = 0; nd = 1; m_phase = PH_WAIT_DROP; end
        else m_hold--;
      end
      default: if (!a) m_phase = PH_IDLE;
    endcase
    m_done = nd;
    m_to = tset ? 1'b1 : (clr ? 1'b0 : m_to);
    m_pe = pset ? 1'b1 : (clr ? 1'b0 : m_pe);
    if (jv && ready) mq.push_back(jl);
  endtask

  task automatic compare_all();
    chk("req", req, m_req);
    chk("busy", busy, (m_phase == PH_OWN));
    chk("done", done, m_done);
    chk("fifo_count", fifo_count, mq.size());
    chk("job_ready", job_ready, (mq.size() < DEPTH));
    chk("timeout_err", timeout_err, m_to);
    chk("proto_err", proto_err, m_pe);
    chk("grant_cnt", grant_cnt, m_grant);
    chk("max_wait", max_wait, m_maxw);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(job_valid, int'(job_len), ack, err_clr);
    #1;
    compare_all();
    if (auto_ack) begin
      if (req) ack = ack ? ($urandom % 32 != 0) : ($urandom % 4 == 0);
      else     ack = ack ? ($urandom % 3 != 0)  : ($urandom % 24 == 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; ack = 1'b0; job_valid = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  int busy_n, done_n, req_n, steps;

  initial begin
    model_reset();
    do_reset();
    chk("reset_req", req, 0);
    chk("reset_ready", job_ready, 1);
    chk("reset_count", fifo_count, 0);

    // Single job: len 3, ack two cycles after req, drops one cycle after req falls.
    job_valid = 1; job_len = 3; cycle();
    job_valid = 0; cycle();
    chk("single_req_rise", req, 1);
    cycle(); cycle(); ack = 1;
    busy_n = 0; done_n = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      busy_n += busy; done_n += done;
      if (!req && !busy && ack) begin cycle(); ack = 0; end
    end
    chk("single_busy_cycles", busy_n, 3);
    chk("single_done_pulses", done_n, 1);
    chk("single_grant", grant_cnt, 1);
    chk("single_max_wait", max_wait, 2);

    // Timeout with ack held low.
    do_reset();
    job_valid = 1; job_len = 2; cycle();
    job_valid = 0;
    req_n = 0; done_n = 0;
    for (int i = 0; i < 20; i++) begin cycle(); req_n += req; done_n += done; end
    chk("timeout_req_cycles", req_n, TIMEOUT);
    chk("timeout_flag", timeout_err, 1);
    chk("timeout_no_done", done_n, 0);
    chk("timeout_grant", grant_cnt, 0);
    chk("timeout_fifo", fifo_count, 0);
    err_clr = 1; cycle(); err_clr = 0;
    chk("timeout_clr", timeout_err, 0);

    // FIFO full: a blocker job occupies the requester while five more are pushed.
    do_reset();
    job_valid = 1; job_len = 1; cycle();
    for (int i = 0; i < 5; i++) begin job_len = LEN_W'(i + 2); cycle(); end
    job_valid = 0;
    chk("full_count", fifo_count, 4);
    chk("full_ready", job_ready, 0);
    steps = 0;
    while (fifo_count == 4 && steps < 40) begin cycle(); steps++; end
    chk("full_after_pop", fifo_count, 3);

    // Randomized traffic.
    do_reset();
    auto_ack = 1;
    for (int i = 0; i < 4000; i++) begin
      job_valid = ($urandom % 3 == 0);
      job_len   = LEN_W'($urandom);
      err_clr   = ($urandom % 16 == 0);
      cycle();
    end
    job_valid = 0; err_clr = 0;

    // Asynchronous reset while the resource is held.
    job_valid = 1; job_len = 15; cycle(); job_valid = 0;
    steps = 0;
    while (!busy && steps < 300) begin cycle(); steps++; end
    chk("reset_found_hold", busy, 1);
    auto_ack = 0;
    #3 reset = 1'b1;
    #1;
    chk("async_req", req, 0);
    chk("async_busy", busy, 0);
    chk("async_count", fifo_count, 0);
    chk("async_grant", grant_cnt, 0);
    @(negedge clk);
    reset = 1'b0; ack = 1'b0;
    model_reset();
    cycle(); cycle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
